// File: rtl/gtfmac_stat_pkg.sv
// Shared address map and the wrap/saturate accumulate used by every
// statistics counter channel.
package gtfmac_stat_pkg;

  localparam int unsigned ADDR_CTRL     = 32'h0000;
  localparam int unsigned ADDR_SNAP_CNT = 32'h0004;
  localparam int unsigned ADDR_OVF      = 32'h0008;
  localparam int unsigned CNT_BASE      = 32'h0100;
  localparam int unsigned CNT_STRIDE    = 8;

  typedef struct packed {
    logic        ovf;
    logic [63:0] sum;
  } add_res_t;

  // Operands are zero-extended counts narrower than width; 65-bit math keeps
  // the carry for width=64.
  function automatic add_res_t stat_add(input logic [63:0] cnt, input logic [63:0] inc,
                                        input int unsigned width, input logic sat);
    logic [64:0] full;
    logic [64:0] lim;
    add_res_t    r;
    full  = {1'b0, cnt} + {1'b0, inc};
    lim   = (65'd1 << width) - 65'd1;
    r.ovf = full > lim;
    r.sum = (r.ovf && sat) ? lim[63:0] : (full[63:0] & lim[63:0]);
    return r;
  endfunction

endpackage

// File: rtl/gtfmac_stat_counter_ch.sv
// One statistics channel: live accumulator, interval shadow and the sticky
// overflow flags for both.
module gtfmac_stat_counter_ch
  import gtfmac_stat_pkg::*;
#(
  parameter int unsigned INC_WIDTH = 14,
  parameter int unsigned CNT_WIDTH = 48,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INC_WIDTH-1:0] inc,
  input  logic                 tick,
  output logic [CNT_WIDTH-1:0] shadow,
  output logic                 ovf_shadow
);

  logic [CNT_WIDTH-1:0] live_q, live_d, shadow_q, shadow_d;
  logic                 ovf_live_q, ovf_live_d, ovf_shadow_q, ovf_shadow_d;
  add_res_t             add_r;
  logic                 unused_sum;

  assign unused_sum = ^add_r;

  // The increment seen in the tick cycle still belongs to the closing interval.
  always_comb begin
    add_r        = stat_add(64'(live_q), 64'(inc), CNT_WIDTH, SATURATE != 0);
    live_d       = add_r.sum[CNT_WIDTH-1:0];
    ovf_live_d   = ovf_live_q | add_r.ovf;
    shadow_d     = shadow_q;
    ovf_shadow_d = ovf_shadow_q;
    if (tick) begin
      shadow_d     = live_d;
      ovf_shadow_d = ovf_live_d;
      live_d       = '0;
      ovf_live_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q       <= '0;
      shadow_q     <= '0;
      ovf_live_q   <= 1'b0;
      ovf_shadow_q <= 1'b0;
    end else begin
      live_q       <= live_d;
      shadow_q     <= shadow_d;
      ovf_live_q   <= ovf_live_d;
      ovf_shadow_q <= ovf_shadow_d;
    end
  end

  assign shadow     = shadow_q;
  assign ovf_shadow = ovf_shadow_q;

endmodule

// File: rtl/gtfmac_wrapper_stat_counter_bank.sv
// Bank of NUM_CH interval statistics counters with an IPIF read port;
// reads only ever see shadow values so they are stable within an interval.
module gtfmac_wrapper_stat_counter_bank
  import gtfmac_stat_pkg::*;
#(
  parameter int unsigned NUM_CH     = 32,
  parameter int unsigned INC_WIDTH  = 14,
  parameter int unsigned CNT_WIDTH  = 48,
  parameter int unsigned SATURATE   = 0,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                        Bus2IP_Clk,
  input  logic                        Bus2IP_Reset,
  input  logic [NUM_CH*INC_WIDTH-1:0] inc_vec,
  input  logic                        pm_tick,
  input  logic [ADDR_WIDTH-1:0]       Bus2IP_Addr,
  input  logic                        Bus2IP_RNW,
  input  logic                        Bus2IP_CS,
  input  logic [31:0]                 Bus2IP_Data,
  output logic [31:0]                 IP2Bus_Data,
  output logic                        IP2Bus_RdAck,
  output logic                        IP2Bus_WrAck,
  output logic                        IP2Bus_RdError,
  output logic                        IP2Bus_WrError,
  output logic                        tick_out
);

  logic [CNT_WIDTH-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0]    ovf_vec;
  logic                 eff_tick, accept, rd_hit, unused_wdata;
  logic [31:0]          addr, cnt_off, ch_idx, rd_word;

  logic        rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
  logic        rd_err_q, rd_err_d, wr_err_q, wr_err_d;
  logic        sw_tick_q, sw_tick_d, tick_out_q, tick_out_d;
  logic [31:0] rd_data_q, rd_data_d, snap_cnt_q, snap_cnt_d;

  assign unused_wdata = ^Bus2IP_Data[31:1];

  // A software tick lands in its WrAck cycle; OR-ing merges it with pm_tick.
  assign eff_tick = pm_tick | sw_tick_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gtfmac_stat_counter_ch #(
      .INC_WIDTH (INC_WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_ch (
      .clk        (Bus2IP_Clk),
      .rst        (Bus2IP_Reset),
      .inc        (inc_vec[i*INC_WIDTH +: INC_WIDTH]),
      .tick       (eff_tick),
      .shadow     (shadow[i]),
      .ovf_shadow (ovf_vec[i])
    );
  end

  always_comb begin
    addr    = 32'(Bus2IP_Addr);
    cnt_off = addr - CNT_BASE;
    ch_idx  = cnt_off >> 3;
    rd_word = 32'h0;
    rd_hit  = 1'b0;
    case (addr)
      ADDR_CTRL:     rd_hit = 1'b1;
      ADDR_SNAP_CNT: begin rd_hit = 1'b1; rd_word = snap_cnt_q; end
      ADDR_OVF:      begin rd_hit = 1'b1; rd_word = 32'(ovf_vec); end
      default: begin
        if (addr >= CNT_BASE && cnt_off < NUM_CH*CNT_STRIDE && addr[1:0] == 2'b00) begin
          rd_hit = 1'b1;
          for (int i = 0; i < NUM_CH; i++)
            if (ch_idx == 32'(i))
              rd_word = cnt_off[2] ? 32'(shadow[i] >> 32) : shadow[i][31:0];
        end
      end
    endcase

    // CS lingering through the ack cycle must not start a second access.
    accept     = Bus2IP_CS & ~(rd_ack_q | wr_ack_q);
    rd_ack_d   = accept & Bus2IP_RNW;
    wr_ack_d   = accept & ~Bus2IP_RNW;
    rd_data_d  = (rd_ack_d && rd_hit) ? rd_word : 32'h0;
    rd_err_d   = rd_ack_d & ~rd_hit;
    wr_err_d   = wr_ack_d & (addr != ADDR_CTRL);
    sw_tick_d  = wr_ack_d & (addr == ADDR_CTRL) & Bus2IP_Data[0];
    tick_out_d = eff_tick;
    snap_cnt_d = snap_cnt_q + 32'(eff_tick);
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      sw_tick_q  <= 1'b0;
      tick_out_q <= 1'b0;
      rd_data_q  <= '0;
      snap_cnt_q <= '0;
    end else begin
      rd_ack_q   <= rd_ack_d;
      wr_ack_q   <= wr_ack_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
      sw_tick_q  <= sw_tick_d;
      tick_out_q <= tick_out_d;
      rd_data_q  <= rd_data_d;
      snap_cnt_q <= snap_cnt_d;
    end
  end

  assign IP2Bus_Data    = rd_data_q;
  assign IP2Bus_RdAck   = rd_ack_q;
  assign IP2Bus_WrAck   = wr_ack_q;
  assign IP2Bus_RdError = rd_err_q;
  assign IP2Bus_WrError = wr_err_q;
  assign tick_out       = tick_out_q;

endmodule

// File: tb/tb_gtfmac_wrapper_stat_counter_bank.sv
// Drives a wrapping and a saturating bank with identical stimulus and checks
// both against a per-cycle reference model plus directed register reads.
module tb_gtfmac_wrapper_stat_counter_bank;
  localparam int NCH = 4;
  localparam int IW  = 32;  // wide increments let a 33-bit counter overflow in a few cycles
  localparam int CW  = 33;
  localparam logic [63:0] LIM = 64'h1_FFFF_FFFF;

  logic              Bus2IP_Clk = 1'b0, Bus2IP_Reset = 1'b1, pm_tick = 1'b0;
  logic              Bus2IP_RNW = 1'b1, Bus2IP_CS = 1'b0;
  logic [NCH*IW-1:0] inc_vec = '0;
  logic [15:0]       Bus2IP_Addr = '0;
  logic [31:0]       Bus2IP_Data = '0;
  logic [31:0]       o_data [2];
  logic              o_rd [2], o_wr [2], o_re [2], o_we [2], o_tick [2];

  always #5 Bus2IP_Clk = ~Bus2IP_Clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gtfmac_wrapper_stat_counter_bank #(
      .NUM_CH(NCH), .INC_WIDTH(IW), .CNT_WIDTH(CW), .SATURATE(g), .ADDR_WIDTH(16)
    ) u_dut (
      .Bus2IP_Clk(Bus2IP_Clk), .Bus2IP_Reset(Bus2IP_Reset), .inc_vec(inc_vec),
      .pm_tick(pm_tick), .Bus2IP_Addr(Bus2IP_Addr), .Bus2IP_RNW(Bus2IP_RNW),
      .Bus2IP_CS(Bus2IP_CS), .Bus2IP_Data(Bus2IP_Data), .IP2Bus_Data(o_data[g]),
      .IP2Bus_RdAck(o_rd[g]), .IP2Bus_WrAck(o_wr[g]), .IP2Bus_RdError(o_re[g]),
      .IP2Bus_WrError(o_we[g]), .tick_out(o_tick[g])
    );
  end

  int n_pass = 0, n_total = 0;

  // Reference state; index 0 = wrapping bank, 1 = saturating bank.
  logic [63:0] m_live [2][NCH], m_sh [2][NCH];
  logic        m_ol [2][NCH], m_os [2][NCH];
  logic [31:0] m_snap = '0;
  logic        m_rd = 0, m_wr = 0, m_re = 0, m_we = 0, m_sw = 0, m_tick = 0;
  logic [31:0] m_data [2];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic logic [64:0] madd(input logic [63:0] a, input logic [63:0] b, input bit sat);
    logic [63:0] s;
    s = a + b;
    if (s > LIM) return {1'b1, sat ? LIM : s - (LIM + 64'd1)};
    return {1'b0, s};
  endfunction

  function automatic logic [32:0] mread(input int d, input logic [31:0] a);
    logic [31:0] off;
    int ch;
    if (a == 32'h0) return {1'b0, 32'h0};
    if (a == 32'h4) return {1'b0, m_snap};
    if (a == 32'h8) return {1'b0, 28'h0, m_os[d][3], m_os[d][2], m_os[d][1], m_os[d][0]};
    if (a >= 32'h100 && a < 32'h100 + 8*NCH && a % 4 == 0) begin
      off = a - 32'h100;
      ch  = int'(off / 8);
      return {1'b0, (off % 8 == 4) ? m_sh[d][ch][63:32] : m_sh[d][ch][31:0]};
    end
    return {1'b1, 32'h0};
  endfunction

  // Advance the model across the coming clock edge using the current inputs.
  task automatic model_step();
    logic eff, acc, n_rd, n_wr, n_sw, n_we, ov;
    logic [1:0] n_re;
    logic [31:0] a;
    logic [31:0] n_d [2];
    logic [63:0] s;
    eff  = pm_tick | m_sw;
    acc  = Bus2IP_CS && !(m_rd || m_wr);
    a    = 32'(Bus2IP_Addr);
    n_rd = acc && Bus2IP_RNW;
    n_wr = acc && !Bus2IP_RNW;
    n_sw = n_wr && a == 0 && Bus2IP_Data[0];
    n_we = n_wr && a != 0;
    n_re = '0;
    n_d[0] = '0; n_d[1] = '0;
    for (int d = 0; d < 2; d++)
      if (n_rd) {n_re[d], n_d[d]} = mread(d, a);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NCH; i++) begin
        {ov, s} = madd(m_live[d][i], 64'(inc_vec[i*IW +: IW]), d == 1);
        if (eff) begin
          m_sh[d][i] = s; m_os[d][i] = m_ol[d][i] | ov;
          m_live[d][i] = '0; m_ol[d][i] = 1'b0;
        end else begin
          m_live[d][i] = s; m_ol[d][i] = m_ol[d][i] | ov;
        end
      end
    m_snap = m_snap + 32'(eff);
    m_rd = n_rd; m_wr = n_wr; m_re = n_re[0]; m_we = n_we; m_sw = n_sw; m_tick = eff;
    m_data[0] = n_d[0]; m_data[1] = n_d[1];
    if (n_re[0] != n_re[1]) $display("FAIL model_err_split: got %0h expected %0h", n_re[1], n_re[0]);
    if (Bus2IP_Reset) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < NCH; i++) begin
          m_live[d][i] = '0; m_sh[d][i] = '0; m_ol[d][i] = 1'b0; m_os[d][i] = 1'b0;
        end
      m_snap = '0; m_rd = 0; m_wr = 0; m_re = 0; m_we = 0; m_sw = 0; m_tick = 0;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge Bus2IP_Clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rdack[%0d]", d), 64'(o_rd[d]), 64'(m_rd));
      chk($sformatf("wrack[%0d]", d), 64'(o_wr[d]), 64'(m_wr));
      chk($sformatf("rderr[%0d]", d), 64'(o_re[d]), 64'(m_rd & m_re));
      chk($sformatf("wrerr[%0d]", d), 64'(o_we[d]), 64'(m_wr & m_we));
      chk($sformatf("tick_out[%0d]", d), 64'(o_tick[d]), 64'(m_tick));
      if (m_rd) chk($sformatf("rdata[%0d]", d), 64'(o_data[d]), 64'(m_data[d]));
    end
  endtask

  task automatic set_inc(input int ch, input logic [31:0] v);
    inc_vec[ch*IW +: IW] = v;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d0, output logic [31:0] d1,
                          output logic e0, output logic e1);
    Bus2IP_CS = 1; Bus2IP_RNW = 1; Bus2IP_Addr = a;
    step();
    chk("rd_latency", 64'(o_rd[0] & o_rd[1]), 64'd1);
    d0 = o_data[0]; d1 = o_data[1]; e0 = o_re[0]; e1 = o_re[1];
    Bus2IP_CS = 0;
    step();
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [31:0] x0,
                        input logic [31:0] x1, input logic xe);
    logic [31:0] d0, d1;
    logic e0, e1;
    bus_read(a, d0, d1, e0, e1);
    chk({nm, "_wrap"}, 64'(d0), 64'(x0));
    chk({nm, "_sat"}, 64'(d1), 64'(x1));
    chk({nm, "_err"}, 64'({e0, e1}), 64'({xe, xe}));
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] dat, input logic pm,
                           output logic e0, output logic e1);
    Bus2IP_CS = 1; Bus2IP_RNW = 0; Bus2IP_Addr = a; Bus2IP_Data = dat;
    step();
    chk("wr_latency", 64'(o_wr[0] & o_wr[1]), 64'd1);
    e0 = o_we[0]; e1 = o_we[1];
    Bus2IP_CS = 0; Bus2IP_RNW = 1; pm_tick = pm;
    step();
    pm_tick = 0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        err;
  } rd_vec_t;

  rd_vec_t tbl [10];
  logic [15:0] addrs [12];

  initial begin
    logic e0, e1;
    tbl[0] = '{16'h0000, 32'h0, 1'b0}; tbl[1] = '{16'h0004, 32'h0, 1'b0};
    tbl[2] = '{16'h0008, 32'h0, 1'b0}; tbl[3] = '{16'h0100, 32'h0, 1'b0};
    tbl[4] = '{16'h0104, 32'h0, 1'b0}; tbl[5] = '{16'h011C, 32'h0, 1'b0};
    tbl[6] = '{16'h0120, 32'h0, 1'b1}; tbl[7] = '{16'h000C, 32'h0, 1'b1};
    tbl[8] = '{16'h0102, 32'h0, 1'b1}; tbl[9] = '{16'h0200, 32'h0, 1'b1};
    addrs = '{16'h0000, 16'h0004, 16'h0008, 16'h0100, 16'h0104, 16'h0108,
              16'h010C, 16'h0110, 16'h0114, 16'h0118, 16'h011C, 16'h0120};

    // Reset state and the constant register table.
    repeat (2) step();
    Bus2IP_Reset = 0;
    step();
    chk("rst_data", 64'(o_data[0] | o_data[1]), 64'd0);
    for (int k = 0; k < 10; k++)
      rd_chk($sformatf("tbl%0d", k), tbl[k].addr, tbl[k].data, tbl[k].data, tbl[k].err);

    // Multi-cycle accumulate then pm_tick; tick_out follows one cycle later.
    set_inc(2, 1500);
    repeat (10) step();
    set_inc(2, 0); pm_tick = 1;
    step();
    pm_tick = 0;
    chk("tick_out_hi", 64'(o_tick[0] & o_tick[1]), 64'd1);
    step();
    chk("tick_out_lo", 64'(o_tick[0] | o_tick[1]), 64'd0);
    rd_chk("ch2_lo", 16'h0110, 15000, 15000, 0);
    rd_chk("ch2_hi", 16'h0114, 0, 0, 0);
    rd_chk("snap1", 16'h0004, 1, 1, 0);

    // Increment in the tick cycle, then a software tick.
    set_inc(0, 5);
    repeat (20) step();
    pm_tick = 1;
    step();
    pm_tick = 0; set_inc(0, 0);
    rd_chk("tick_inc", 16'h0100, 105, 105, 0);
    set_inc(0, 5);
    repeat (3) step();
    set_inc(0, 0);
    bus_write(16'h0000, 32'h1, 0, e0, e1);
    chk("swtick_err", 64'({e0, e1}), 64'd0);
    rd_chk("swtick", 16'h0100, 15, 15, 0);
    rd_chk("snap3", 16'h0004, 3, 3, 0);

    // Overflow past 2^33: wrap vs clamp, then OVF clears next interval.
    set_inc(1, 32'hFFFF_FFFF);
    repeat (3) step();
    set_inc(1, 0); pm_tick = 1;
    step();
    pm_tick = 0;
    rd_chk("ovf_lo", 16'h0108, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    rd_chk("ovf_hi", 16'h010C, 0, 1, 0);
    rd_chk("ovf_bit", 16'h0008, 2, 2, 0);
    pm_tick = 1;
    step();
    pm_tick = 0;
    rd_chk("ovf_clr", 16'h0008, 0, 0, 0);

    // Error paths and coincident ticks.
    set_inc(3, 7);
    repeat (2) step();
    set_inc(3, 0); pm_tick = 1;
    step();
    pm_tick = 0;
    rd_chk("oob", 16'h0120, 0, 0, 1);
    bus_write(16'h0118, 32'hFFFF_FFFF, 0, e0, e1);
    chk("bad_wr_err", 64'({e0, e1}), 64'h3);
    rd_chk("bad_wr_keep", 16'h0118, 14, 14, 0);
    rd_chk("snap6", 16'h0004, 6, 6, 0);
    bus_write(16'h0000, 32'h2, 0, e0, e1);
    rd_chk("ctrl_bit1", 16'h0004, 6, 6, 0);
    bus_write(16'h0000, 32'h1, 1, e0, e1);
    rd_chk("dual_tick", 16'h0004, 7, 7, 0);

    // Reset in the accept cycle drops the ack and clears everything.
    Bus2IP_CS = 1; Bus2IP_RNW = 1; Bus2IP_Addr = 16'h0118; Bus2IP_Reset = 1;
    step();
    chk("rst_drop", 64'(o_rd[0] | o_rd[1]), 64'd0);
    Bus2IP_Reset = 0; Bus2IP_CS = 0;
    step();
    chk("rst_noack", 64'(o_rd[0] | o_rd[1]), 64'd0);
    rd_chk("rst_ch3", 16'h0118, 0, 0, 0);
    rd_chk("rst_snap", 16'h0004, 0, 0, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NCH; i++) begin
        case ($urandom_range(0, 3))
          0: set_inc(i, 0);
          1: set_inc(i, 32'($urandom_range(0, 1500)));
          2: set_inc(i, $urandom);
          default: set_inc(i, 32'hFFFF_FFFF);
        endcase
      end
      pm_tick     = ($urandom_range(0, 11) == 0);
      Bus2IP_CS   = ($urandom_range(0, 2) == 0);
      Bus2IP_RNW  = ($urandom_range(0, 3) != 0);
      Bus2IP_Addr = addrs[$urandom_range(0, 11)];
      Bus2IP_Data = $urandom;
      step();
    end
    inc_vec = '0; pm_tick = 0; Bus2IP_CS = 0; Bus2IP_RNW = 1;
    repeat (2) step();
    for (int k = 0; k < 12; k++) begin
      logic [31:0] d0, d1;
      bus_read(addrs[k], d0, d1, e0, e1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
